// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit driving a req/gnt/rvalid data-memory bus
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              stall_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              misalign_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                we_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                mis_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                mis_in;
  logic                load_en;
  logic                capture_en;
  logic [1:0]          off;
  logic [DATA_W-1:0]   lane_shifted;
  logic [DATA_W-1:0]   load_ext;

  assign mis_in     = ((req_size_i == 2'b01) & req_addr_i[0]) |
                      (req_size_i[1] & (req_addr_i[1:0] != 2'b00));
  assign load_en    = (state_q == IDLE) & req_valid_i;
  assign capture_en = ((state_q == REQ) & mem_gnt_i & mem_rvalid_i) |
                      ((state_q == WAIT) & mem_rvalid_i);
  assign off        = addr_q[1:0];

  // Shift the addressed lane down to bit 0 before extension.
  assign lane_shifted = mem_rdata_i >> {off, 3'b000};

  always_comb begin
    load_ext = '0;
    if (!we_q) begin
      case (size_q)
        2'b00:   load_ext = uns_q ? {{(DATA_W-8){1'b0}}, lane_shifted[7:0]}
                                  : {{(DATA_W-8){lane_shifted[7]}}, lane_shifted[7:0]};
        2'b01:   load_ext = uns_q ? {{(DATA_W-16){1'b0}}, lane_shifted[15:0]}
                                  : {{(DATA_W-16){lane_shifted[15]}}, lane_shifted[15:0]};
        default: load_ext = mem_rdata_i;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid_i) state_d = mis_in ? RESP : REQ;
      REQ:  if (mem_gnt_i)   state_d = mem_rvalid_i ? RESP : WAIT;
      WAIT: if (mem_rvalid_i) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (load_en) begin
        we_q    <= req_we_i;
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        mis_q   <= mis_in;
        rdata_q <= '0;
      end else if (capture_en) begin
        rdata_q <= load_ext;
      end else if (state_q == RESP) begin
        mis_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = 4'b0000;
    mem_wdata_o = '0;
    if (state_q == REQ) begin
      mem_req_o  = 1'b1;
      mem_we_o   = we_q;
      mem_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
      case (size_q)
        2'b00: begin
          mem_be_o    = 4'b0001 << off;
          mem_wdata_o = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          mem_be_o    = 4'b0011 << off;
          mem_wdata_o = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_be_o    = 4'b1111;
          mem_wdata_o = wdata_q;
        end
      endcase
    end
    stall_o     = (state_q == REQ) | (state_q == WAIT) | ((state_q == IDLE) & req_valid_i);
    rsp_valid_o = (state_q == RESP);
    rsp_rdata_o = rdata_q;
    misalign_o  = mis_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        stall_o;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        misalign_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .stall_o(stall_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .misalign_o(misalign_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one access and acts as the memory; gnt after gnt_wait request cycles,
  // rvalid rv_wait cycles after the grant (0 = same cycle as gnt).
  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                        input logic exp_mis, input int exp_reqs, input int exp_stalls);
    int  reqs = 0;
    int  stalls = 0;
    int  waits = 0;
    bit  granted = 0;
    bit  done = 0;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata; mem_rdata_i = rdata;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      if (stall_o) stalls++;
      if (mem_req_o) begin
        reqs++;
        check_eq({tag, "_addr"}, mem_addr_o, exp_addr);
        check_eq({tag, "_be"}, {28'b0, mem_be_o}, {28'b0, exp_be});
        check_eq({tag, "_we"}, {31'b0, mem_we_o}, {31'b0, we});
        check_eq({tag, "_wdata"}, mem_wdata_o, exp_wdata);
        if (reqs > gnt_wait) begin
          mem_gnt_i = 1'b1; granted = 1;
          if (rv_wait == 0) mem_rvalid_i = 1'b1;
        end
      end else if (granted && !rsp_valid_o) begin
        waits++;
        if (waits == rv_wait) mem_rvalid_i = 1'b1;
      end
      if (rsp_valid_o) begin
        check_eq({tag, "_rdata"}, rsp_rdata_o, exp_rdata);
        check_eq({tag, "_mis"}, {31'b0, misalign_o}, {31'b0, exp_mis});
        check_eq({tag, "_rsp_stall"}, {31'b0, stall_o}, 32'd0);
        req_valid_i = 1'b0;
        done = 1;
      end
    end
    check_eq({tag, "_done"}, {31'b0, done}, 32'd1);
    check_eq({tag, "_reqs"}, reqs, exp_reqs);
    check_eq({tag, "_stalls"}, stalls, exp_stalls);
    @(negedge clk); #1;
    check_eq({tag, "_one_pulse"}, {31'b0, rsp_valid_o}, 32'd0);
    check_eq({tag, "_mis_clr"}, {31'b0, misalign_o}, 32'd0);
    check_eq({tag, "_rdata_clr"}, rsp_rdata_o, 32'd0);
  endtask

  initial begin
    int reqs, rsps, first_req, second_req;
    #12;
    check_eq("rst_stall", {31'b0, stall_o}, 32'd0);
    check_eq("rst_req", {31'b0, mem_req_o}, 32'd0);
    check_eq("rst_rsp", {31'b0, rsp_valid_o}, 32'd0);
    check_eq("rst_addr", mem_addr_o, 32'd0);
    check_eq("rst_rdata", rsp_rdata_o, 32'd0);
    @(negedge clk); rst = 1'b1;

    access("lb", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 0, 32'h80AA_BBCC,
           32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 1, 2);
    access("lhu", 1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 3, 2, 32'h9ABC_0000,
           32'h200, 4'b1100, 32'h0, 32'h0000_9ABC, 1'b0, 4, 7);
    access("sb", 1'b1, 2'b00, 1'b0, 32'h301, 32'h1234_5677, 1, 1, 32'hFFFF_FFFF,
           32'h300, 4'b0010, 32'h7777_7777, 32'h0, 1'b0, 2, 4);
    access("lw_mis", 1'b0, 2'b10, 1'b0, 32'h402, 32'h0, 0, 0, 32'h5555_5555,
           32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 0, 1);
    access("sh_mis", 1'b1, 2'b01, 1'b0, 32'h405, 32'hABCD, 0, 0, 32'h0,
           32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 0, 1);

    // Reset while waiting for rvalid.
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h0;
    @(negedge clk); #1;
    check_eq("rst5_req", {31'b0, mem_req_o}, 32'd1);
    mem_gnt_i = 1'b1;
    @(negedge clk); #1;
    mem_gnt_i = 1'b0;
    check_eq("rst5_wait_req", {31'b0, mem_req_o}, 32'd0);
    check_eq("rst5_wait_stall", {31'b0, stall_o}, 32'd1);
    #2; rst = 1'b0; req_valid_i = 1'b0; #1;
    check_eq("rst5_stall", {31'b0, stall_o}, 32'd0);
    check_eq("rst5_rsp", {31'b0, rsp_valid_o}, 32'd0);
    check_eq("rst5_memreq", {31'b0, mem_req_o}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111;
    @(negedge clk); #1; mem_rvalid_i = 1'b0;
    check_eq("rst5_late_rsp", {31'b0, rsp_valid_o}, 32'd0);
    check_eq("rst5_late_rdata", rsp_rdata_o, 32'd0);
    access("lw0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 0, 32'hDEAD_BEEF,
           32'h0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 2);

    // Back-to-back LW then SW with req_valid held high.
    reqs = 0; rsps = 0; first_req = 0; second_req = 0;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h10; req_wdata_i = 32'h0; mem_rdata_i = 32'h1234_5678;
    for (int c = 1; c < 12; c++) begin
      @(negedge clk); #1;
      mem_gnt_i = mem_req_o; mem_rvalid_i = mem_req_o;
      if (mem_req_o) begin
        reqs++;
        if (reqs == 1) first_req = c;
        if (reqs == 2) begin
          second_req = c;
          check_eq("b2b_sw_we", {31'b0, mem_we_o}, 32'd1);
          check_eq("b2b_sw_addr", mem_addr_o, 32'h14);
          check_eq("b2b_sw_wdata", mem_wdata_o, 32'hCAFE_F00D);
          check_eq("b2b_sw_be", {28'b0, mem_be_o}, 32'hF);
        end
      end
      if (rsp_valid_o) begin
        rsps++;
        if (rsps == 1) begin
          check_eq("b2b_lw_rdata", rsp_rdata_o, 32'h1234_5678);
          req_we_i = 1'b1; req_addr_i = 32'h14; req_wdata_i = 32'hCAFE_F00D;
        end else begin
          check_eq("b2b_sw_rdata", rsp_rdata_o, 32'h0);
          req_valid_i = 1'b0;
        end
      end
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    check_eq("b2b_reqs", reqs, 32'd2);
    check_eq("b2b_rsps", rsps, 32'd2);
    check_eq("b2b_gap", second_req - first_req, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
